// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, issues instruction-memory requests and buffers one word across ID stalls.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MIO_ready,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_addr,
  output logic        inst_req,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] branchTarget,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcPlus4,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] buf_inst, buf_inst_nx;
  logic [31:0] buf_pc, buf_pc_nx;
  logic [31:0] redirect_pc, redirect_pc_nx;
  logic [31:0] id_inst_nx, id_pc_nx, id_pcp4_nx;
  logic        id_valid_nx;
  logic [31:0] pc_plus4;
  logic [31:0] buf_pc_plus4;

  assign pc_plus4     = pc + 32'd4;
  assign buf_pc_plus4 = buf_pc + 32'd4;

  assign inst_addr = pc;
  assign inst_req  = (state != HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      buf_inst       <= '0;
      buf_pc         <= '0;
      redirect_pc    <= '0;
      id_instruction <= NOP_INST;
      id_pc          <= '0;
      id_pcPlus4     <= 32'd4;
      id_valid       <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      buf_inst       <= buf_inst_nx;
      buf_pc         <= buf_pc_nx;
      redirect_pc    <= redirect_pc_nx;
      id_instruction <= id_inst_nx;
      id_pc          <= id_pc_nx;
      id_pcPlus4     <= id_pcp4_nx;
      id_valid       <= id_valid_nx;
    end
  end

  // A bubble replaces instruction/valid only; id_pc and id_pcPlus4 keep their last values.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    buf_inst_nx    = buf_inst;
    buf_pc_nx      = buf_pc;
    redirect_pc_nx = redirect_pc;
    id_inst_nx     = id_instruction;
    id_pc_nx       = id_pc;
    id_pcp4_nx     = id_pcPlus4;
    id_valid_nx    = id_valid;

    unique case (state)
      FETCH: begin
        if (shouldJumpOrBranch) begin
          id_inst_nx  = NOP_INST;
          id_valid_nx = 1'b0;
          if (MIO_ready) begin
            pc_nx = branchTarget;
          end else begin
            // Keep the address stable until the in-flight access completes.
            redirect_pc_nx = branchTarget;
            state_nx       = DISCARD;
          end
        end else if (shouldStall) begin
          if (MIO_ready) begin
            buf_inst_nx = inst_in;
            buf_pc_nx   = pc;
            pc_nx       = pc_plus4;
            state_nx    = HOLD;
          end
        end else if (MIO_ready) begin
          id_inst_nx  = inst_in;
          id_pc_nx    = pc;
          id_pcp4_nx  = pc_plus4;
          id_valid_nx = 1'b1;
          pc_nx       = pc_plus4;
        end else begin
          id_inst_nx  = NOP_INST;
          id_valid_nx = 1'b0;
        end
      end

      HOLD: begin
        if (shouldJumpOrBranch) begin
          pc_nx       = branchTarget;
          id_inst_nx  = NOP_INST;
          id_valid_nx = 1'b0;
          state_nx    = FETCH;
        end else if (!shouldStall) begin
          id_inst_nx  = buf_inst;
          id_pc_nx    = buf_pc;
          id_pcp4_nx  = buf_pc_plus4;
          id_valid_nx = 1'b1;
          state_nx    = FETCH;
        end
      end

      DISCARD: begin
        id_inst_nx  = NOP_INST;
        id_valid_nx = 1'b0;
        if (shouldJumpOrBranch) begin
          redirect_pc_nx = branchTarget;
        end
        if (MIO_ready) begin
          pc_nx    = shouldJumpOrBranch ? branchTarget : redirect_pc;
          state_nx = FETCH;
        end
      end

      default: begin
        state_nx = FETCH;
      end
    endcase
  end

endmodule
